// File: rtl/split_demux_if.sv
// Beat-in / lane-out bundle for split_demux: master drives beats, slave
// (the demux) drives per-lane outputs and error status.
interface split_demux_if #(
   parameter int WIDTH = 32,
   parameter int CNT   = 31
);
   logic                   din_vld;
   logic [WIDTH-1:0]       din;
   logic [CNT-1:0]         sel;
   logic [CNT-1:0]         dout_vld;
   logic [WIDTH*CNT-1:0]   dout;
   logic                   sel_err;
   logic [7:0]             err_cnt;

   modport master (
      output din_vld, din, sel,
      input  dout_vld, dout, sel_err, err_cnt
   );

   modport slave (
      input  din_vld, din, sel,
      output dout_vld, dout, sel_err, err_cnt
   );
endinterface

// File: rtl/split_demux.sv
// Two-level pipelined one-hot demultiplexer: level 1 decodes select per group,
// level 2 resolves across groups, delivers to one sticky lane or rejects.
module split_demux #(
   parameter int WIDTH      = 32,
   parameter int CNT        = 31,
   parameter int GROUP_SIZE = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   split_demux_if.slave   bus
);
   localparam int GROUP_COUNT = CNT / GROUP_SIZE;
   localparam int REM_SIZE    = CNT % GROUP_SIZE;
   localparam int NGRP        = GROUP_COUNT + ((REM_SIZE != 0) ? 1 : 0);

   logic [NGRP-1:0]        seen_l1;
   logic [NGRP-1:0]        hit_d, hit_q;
   logic [NGRP-1:0]        multi_d, multi_q;
   logic [CNT-1:0]         lsel_q;
   logic [WIDTH-1:0]       data_q;
   logic                   vld_q;

   logic                   hit_any, hit_multi, ok, rej;
   logic [CNT-1:0]         dout_vld_d, dout_vld_q;
   logic [WIDTH*CNT-1:0]   dout_d, dout_q;
   logic                   sel_err_d, sel_err_q;
   logic [7:0]             err_cnt_d, err_cnt_q;

   // Per-group "seen one already" tracking flags a second set bit without popcount.
   always_comb begin
      seen_l1 = '0;
      multi_d = '0;
      for (int unsigned k = 0; k < CNT; k++) begin
         multi_d[k/GROUP_SIZE] = multi_d[k/GROUP_SIZE] | (seen_l1[k/GROUP_SIZE] & bus.sel[k]);
         seen_l1[k/GROUP_SIZE] = seen_l1[k/GROUP_SIZE] | bus.sel[k];
      end
      hit_d   = seen_l1 & {NGRP{bus.din_vld}};
      multi_d = multi_d & {NGRP{bus.din_vld}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         hit_q   <= '0;
         multi_q <= '0;
         lsel_q  <= '0;
         data_q  <= '0;
      end else begin
         vld_q   <= bus.din_vld;
         hit_q   <= hit_d;
         multi_q <= multi_d;
         lsel_q  <= bus.sel;
         data_q  <= bus.din;
      end
   end

   always_comb begin
      hit_any   = 1'b0;
      hit_multi = 1'b0;
      for (int unsigned g = 0; g < NGRP; g++) begin
         hit_multi = hit_multi | (hit_any & hit_q[g]);
         hit_any   = hit_any | hit_q[g];
      end
      ok  = vld_q & hit_any & ~hit_multi & ~(|multi_q);
      rej = vld_q & ~ok;

      dout_vld_d = '0;
      dout_d     = dout_q;
      for (int unsigned k = 0; k < CNT; k++) begin
         dout_vld_d[k] = ok & hit_q[k/GROUP_SIZE] & lsel_q[k];
         if (dout_vld_d[k]) begin
            dout_d[k*WIDTH +: WIDTH] = data_q;
         end
      end

      sel_err_d = rej;
      err_cnt_d = err_cnt_q;
      if (rej && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_vld_q <= '0;
         dout_q     <= '0;
         sel_err_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         dout_vld_q <= dout_vld_d;
         dout_q     <= dout_d;
         sel_err_q  <= sel_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.dout_vld = dout_vld_q;
   assign bus.dout     = dout_q;
   assign bus.sel_err  = sel_err_q;
   assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_split_demux.sv
// Bench for split_demux: table vectors and sequences feed a scoreboard queue
// plus a lane/error-count model; a second small instance covers one group.
module tb_split_demux;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   split_demux_if #(.WIDTH(32), .CNT(31)) bus ();
   split_demux_if #(.WIDTH(32), .CNT(4))  bus4 ();

   split_demux #(.WIDTH(32), .CNT(31), .GROUP_SIZE(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   split_demux #(.WIDTH(32), .CNT(4), .GROUP_SIZE(8)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   typedef struct {
      logic [30:0] vld;
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      logic        v;
      logic [30:0] s;
      logic [31:0] d;
      logic [30:0] exp_vld;
      logic        exp_err;
   } vec_t;

   exp_t        sb[$];
   logic [31:0] model_lane [31];
   int          model_err;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic tick(input logic rstn, input logic v, input logic [30:0] s,
                       input logic [31:0] d, input logic [30:0] ev, input logic ee);
      exp_t push_e, cur, idle;
      rst_n       = rstn;
      bus.din_vld = v;
      bus.sel     = s;
      bus.din     = d;
      push_e.vld  = ev;
      push_e.err  = ee;
      push_e.data = d;
      sb.push_back(push_e);
      @(posedge clk);
      #1;
      idle.vld  = '0;
      idle.err  = 1'b0;
      idle.data = '0;
      if (!rstn) begin
         sb.delete();
         sb.push_back(idle);
         for (int k = 0; k < 31; k++) model_lane[k] = '0;
         model_err = 0;
         cur = idle;
      end else begin
         cur = sb.pop_front();
         for (int k = 0; k < 31; k++)
            if (cur.vld[k]) model_lane[k] = cur.data;
         if (cur.err && model_err < 255) model_err++;
      end
      chk("dout_vld", {33'b0, bus.dout_vld}, {33'b0, cur.vld});
      chk("sel_err", {63'b0, bus.sel_err}, {63'b0, cur.err});
      chk("err_cnt", {56'b0, bus.err_cnt}, 64'(model_err));
      for (int k = 0; k < 31; k++)
         chk($sformatf("lane%0d", k), {32'b0, bus.dout[k*32 +: 32]}, {32'b0, model_lane[k]});
   endtask

   task automatic beat(input logic v, input logic [30:0] s, input logic [31:0] d);
      logic legal;
      legal = v && $onehot(s);
      tick(1'b1, v, s, d, legal ? s : 31'b0, v && !legal);
   endtask

   task automatic reset_pulse();
      tick(1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1'b1, 31'h0000_0001, 32'hA5A5_0000, 31'h0000_0001, 1'b0};
      tbl[1] = '{1'b1, 31'h4000_0000, 32'h0000_5A5A, 31'h4000_0000, 1'b0};
      tbl[2] = '{1'b1, 31'h0000_0000, 32'h0000_DEAD, 31'h0000_0000, 1'b1};
      tbl[3] = '{1'b1, 31'h0000_0003, 32'h0000_BEEF, 31'h0000_0000, 1'b1};
      tbl[4] = '{1'b1, 31'h0010_0004, 32'h0000_CAFE, 31'h0000_0000, 1'b1};
      tbl[5] = '{1'b0, 31'h7FFF_FFFF, 32'h0000_1111, 31'h0000_0000, 1'b0};
      tbl[6] = '{1'b1, 31'h0000_0100, 32'h0000_0008, 31'h0000_0100, 1'b0};
      tbl[7] = '{1'b1, 31'h0100_0000, 32'h0000_0018, 31'h0100_0000, 1'b0};

      bus4.din_vld = 1'b0;
      bus4.sel     = '0;
      bus4.din     = '0;
      model_err    = 0;

      reset_pulse();
      reset_pulse();

      // table vectors, then drain the pipeline
      for (int i = 0; i < 8; i++)
         tick(1'b1, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].exp_vld, tbl[i].exp_err);
      beat(1'b0, '0, '0);
      beat(1'b0, '0, '0);
      chk("tbl_lane0", {32'b0, bus.dout[0 +: 32]}, 64'hA5A5_0000);
      chk("tbl_lane30", {32'b0, bus.dout[30*32 +: 32]}, 64'h0000_5A5A);
      chk("tbl_err_cnt", {56'b0, bus.err_cnt}, 64'd3);

      // streaming: 31 back-to-back one-hot beats
      reset_pulse();
      for (int i = 0; i < 31; i++) beat(1'b1, 31'(1) << i, 32'(i));
      beat(1'b0, '0, '0);
      beat(1'b0, '0, '0);
      chk("stream_lane17", {32'b0, bus.dout[17*32 +: 32]}, 64'd17);
      chk("stream_err_cnt", {56'b0, bus.err_cnt}, 64'd0);

      // saturation, then invalid beats with garbage select
      for (int i = 0; i < 300; i++) beat(1'b1, '0, 32'(i));
      for (int i = 0; i < 4; i++) beat(1'b0, 31'($urandom), $urandom);
      chk("sat_err_cnt", {56'b0, bus.err_cnt}, 64'd255);

      // reset while beats to lanes 5 and 6 are in flight
      beat(1'b1, 31'(1) << 5, 32'h0000_0055);
      tick(1'b0, 1'b1, 31'(1) << 6, 32'h0000_0066, '0, 1'b0);
      chk("rst_dout_zero", {63'b0, (bus.dout == '0)}, 64'd1);
      beat(1'b1, 31'(1) << 7, 32'h0000_0077);
      chk("rst_lane7_early", {33'b0, bus.dout_vld}, 64'd0);
      beat(1'b0, '0, '0);
      chk("rst_lane7_late", {33'b0, bus.dout_vld}, 64'h80);
      beat(1'b0, '0, '0);

      // single-group instance
      bus4.din_vld = 1'b1;
      bus4.sel     = 4'h8;
      bus4.din     = 32'h0000_1234;
      @(posedge clk);
      #1;
      bus4.din_vld = 1'b0;
      bus4.sel     = '0;
      chk("g1_vld_early", {60'b0, bus4.dout_vld}, 64'h0);
      @(posedge clk);
      #1;
      chk("g1_vld", {60'b0, bus4.dout_vld}, 64'h8);
      chk("g1_lane3", {32'b0, bus4.dout[3*32 +: 32]}, 64'h1234);
      chk("g1_err_clear", {63'b0, bus4.sel_err}, 64'd0);
      bus4.din_vld = 1'b1;
      bus4.sel     = 4'hC;
      bus4.din     = 32'h0000_9999;
      @(posedge clk);
      #1;
      bus4.din_vld = 1'b0;
      bus4.sel     = '0;
      chk("g1_err_early", {63'b0, bus4.sel_err}, 64'd0);
      @(posedge clk);
      #1;
      chk("g1_err", {63'b0, bus4.sel_err}, 64'd1);
      chk("g1_err_vld", {60'b0, bus4.dout_vld}, 64'h0);
      chk("g1_err_cnt", {56'b0, bus4.err_cnt}, 64'd1);
      chk("g1_lane3_hold", {32'b0, bus4.dout[3*32 +: 32]}, 64'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
